score_display_bcd: RTL and testbench
====================================

Name: score_display_bcd

Overview:
Parametrised BCD score engine with an on-screen renderer for the game HUD. Keeps an N-digit decimal score that counts up on a programmable tick while the player is not hit, and accepts bonus points. It also renders the digits as a right-aligned row of glyph boxes through a 2-stage pixel pipeline driven by the VGA timing's display_col/display_row. Glyph bitmaps come from an external synchronous glyph ROM.

Parameters:
DIGITS, 4, number of BCD digits (1..8)
TICK_CYCLES, 20000000, clocks per +1 score increment
X_RIGHT, 1150, left x of the least-significant digit box
Y_TOP, 50, top y of all digit boxes
DIGIT_PITCH, 64, x distance between adjacent digit boxes (digit k at X_RIGHT - k*DIGIT_PITCH)
GLYPH_W, 48, digit box width in pixels
GLYPH_H, 64, digit box height in pixels
SATURATE, 0, 0 = wrap modulo 10^DIGITS on overflow; 1 = hold at all nines
FG_RGB, 12'hFFF, normal glyph colour {r,g,b}
OVF_RGB, 12'hF00, glyph colour once overflow is set

Ports:
clock  in  1  pixel/system clock
reset  in  1  asynchronous, active-high
display_col  in  12  current pixel column
display_row  in  11  current pixel row
visible  in  1  active-video flag for current pixel
hit  in  1  1 = pause scoring (tick counter holds, bonus ignored)
clear  in  1  synchronous score clear
bonus_valid  in  1  one-cycle strobe: add bonus_amt
bonus_amt  in  4  bonus value, BCD 0..9
score_bcd  out  4*DIGITS  current score, digit 0 in [3:0]
overflow  out  1  sticky: a carry left the top digit
glyph_digit  out  4  digit value to glyph ROM (registered)
glyph_x  out  6  x offset inside box (registered)
glyph_y  out  6  y offset inside box (registered)
glyph_pixel  in  1  ROM output, valid one clock after glyph_* address
num_red, num_green, num_blue  out  4 each  pixel colour
num_visible  out  1  pixel lies inside a displayed digit box

Behaviour:
- Reset (async): score 0, tick counter 0, overflow 0, glyph_* 0, all colour outputs 0, num_visible 0, pipeline valids 0.
- Tick counter: increments when hit=0. At TICK_CYCLES-1 it returns to 0 and asserts an internal tick for 1 cycle. With hit=1 the counter holds its value; no reset on hit.
- Update amount per cycle: tick (1) + (bonus_valid && !hit && bonus_amt<=9 ? bonus_amt : 0). Range 0..10. bonus_amt>9 is ignored.
- BCD add: add the amount at digit 0 and ripple the decimal carry through all DIGITS in the same cycle. Score is updated on the next clock edge; score_bcd is registered.
- Carry out of the top digit sets overflow (sticky):
  - SATURATE=0: the score is the wrapped value.
  - SATURATE=1: the score is forced to all nines, and further adds leave it at all nines.
- clear: on the next edge, score, tick counter and overflow go to 0. clear beats tick and bonus in the same cycle and is honoured while hit=1.
- Render pipeline, stage 1 (registered):
  - Compute in_box for digit k: col in [X_RIGHT-k*DIGIT_PITCH, +GLYPH_W) and row in [Y_TOP, Y_TOP+GLYPH_H).
  - Register glyph_digit = score digit k, glyph_x = col offset, glyph_y = row offset, and s1_valid = visible && any in_box.
  - Boxes never overlap (DIGIT_PITCH >= GLYPH_W); the lowest k wins if misconfigured.
- Render pipeline, stage 2 (registered):
  - num_visible = s1_valid.
  - If glyph_pixel=1: colour = overflow ? OVF_RGB : FG_RGB. Otherwise colour = 0.
- Total latency is 2 clocks from display_col/row to num_*. The caller delays its own sync signals to match.
- Score change mid-frame: stage 1 samples the digit value live. Tearing is acceptable; no frame latch.
- visible=0 forces num_visible=0 two clocks later.

Optional Feature:
SCORE_LZ_BLANK_EN — when defined, leading zero digits are blanked: digit k>0 is blanked if it and all higher digits are 0. For a blanked digit, s1_valid=0, so num_visible=0 and colour=0. Digit 0 is always shown. Without the macro, all DIGITS boxes are always shown, including leading zeros.

Test Plan:
- TICK_CYCLES=4, hit=0 for 40 clocks from reset -> score_bcd=16'h0010, overflow=0.
- TICK_CYCLES=4, hit=1 for 20 clocks mid-count, then release -> score frozen during hit; the next tick arrives exactly at the remaining count.
- Score 16'h0099, bonus_valid with bonus_amt=5 coinciding with a tick -> 16'h0105 next cycle. bonus_amt=12 -> ignored.
- SATURATE=0, score 16'h9998, bonus 3 -> 16'h0001, overflow=1. SATURATE=1, same stimulus -> 16'h9999, overflow=1. clear -> 0, overflow=0.
- Sweep col 1150..1197 at row 60, digit 0 = 7, ROM model returns 1 -> num_visible=1 and RGB=FFF two clocks after each pixel. Col 1198 -> num_visible=0.
- SCORE_LZ_BLANK_EN defined, score 16'h0042, row 60, col 958 and col 1022 -> num_visible=0 for digits 3 and 2; col 1086 -> num_visible=1.

Source files
------------

// File: rtl/score_display_bcd.sv
// BCD score engine with a right-aligned glyph renderer for the game HUD (2-clock pixel pipeline).
// Optional leading-zero blanking of the upper digits: define SCORE_LZ_BLANK_EN.
module score_display_bcd #(
   parameter int          DIGITS      = 4,
   parameter int          TICK_CYCLES = 20000000,
   parameter int          X_RIGHT     = 1150,
   parameter int          Y_TOP       = 50,
   parameter int          DIGIT_PITCH = 64,
   parameter int          GLYPH_W     = 48,
   parameter int          GLYPH_H     = 64,
   parameter int          SATURATE    = 0,
   parameter logic [11:0] FG_RGB      = 12'hFFF,
   parameter logic [11:0] OVF_RGB     = 12'hF00
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [11:0]           display_col,
   input  logic [10:0]           display_row,
   input  logic                  visible,
   input  logic                  hit,
   input  logic                  clear,
   input  logic                  bonus_valid,
   input  logic [3:0]            bonus_amt,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic                  overflow,
   output logic [3:0]            glyph_digit,
   output logic [5:0]            glyph_x,
   output logic [5:0]            glyph_y,
   input  logic                  glyph_pixel,
   output logic [3:0]            num_red,
   output logic [3:0]            num_green,
   output logic [3:0]            num_blue,
   output logic                  num_visible
);

   localparam int                  SW        = 4 * DIGITS;
   localparam int                  CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
   localparam logic [SW-1:0]       ALL_NINES = {DIGITS{4'h9}};
   localparam logic signed [15:0]  GW_S      = 16'(GLYPH_W);
   localparam logic signed [15:0]  GH_S      = 16'(GLYPH_H);
   localparam logic signed [15:0]  Y_TOP_S   = 16'(Y_TOP);

   // Decimal ripple add of a 0..10 amount; MSB of the result is the carry out of the top digit.
   function automatic logic [SW:0] bcd_add(input logic [SW-1:0] s, input logic [3:0] amt);
      logic [SW-1:0] r;
      logic [4:0]    sum;
      logic [4:0]    carry;
      r     = '0;
      carry = {1'b0, amt};
      for (int k = 0; k < DIGITS; k++) begin
         sum = {1'b0, s[4*k +: 4]} + carry;
         if (sum > 5'd9) begin
            r[4*k +: 4] = 4'(sum - 5'd10);
            carry       = 5'd1;
         end else begin
            r[4*k +: 4] = sum[3:0];
            carry       = 5'd0;
         end
      end
      return {carry[0], r};
   endfunction

   function automatic logic [SW-1:0] saturate_bcd(input logic [SW-1:0] s, input logic cout);
      return ((SATURATE != 0) && cout) ? ALL_NINES : s;
   endfunction

   function automatic logic signed [15:0] box_left(input int k);
      return 16'(X_RIGHT - k * DIGIT_PITCH);
   endfunction

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   logic [3:0]       add_amt;
   logic [SW:0]      add_res;
   logic [SW-1:0]    score_next;

   assign tick = !hit && (tick_cnt == CNT_LAST);

   always_comb begin
      add_amt = {3'b000, tick};
      if (bonus_valid && !hit && (bonus_amt <= 4'd9))
         add_amt = add_amt + bonus_amt;
      add_res    = bcd_add(score_bcd, add_amt);
      score_next = saturate_bcd(add_res[SW-1:0], add_res[SW]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt  <= '0;
         score_bcd <= '0;
         overflow  <= 1'b0;
      end else if (clear) begin
         tick_cnt  <= '0;
         score_bcd <= '0;
         overflow  <= 1'b0;
      end else begin
         if (!hit)
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         score_bcd <= score_next;
         if (add_res[SW])
            overflow <= 1'b1;
      end
   end

   logic [DIGITS-1:0] lz_blank;
`ifdef SCORE_LZ_BLANK_EN
   logic lz_zero_above;
   always_comb begin
      lz_zero_above = 1'b1;
      lz_blank      = '0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         lz_zero_above = lz_zero_above && (score_bcd[4*k +: 4] == 4'd0);
         lz_blank[k]   = lz_zero_above;
      end
   end
`else
   assign lz_blank = '0;
`endif

   logic signed [15:0] col_s, row_s, dx, dy;
   logic               row_ok, in_any;
   logic [3:0]         digit_sel;
   logic [5:0]         x_sel, y_sel;

   assign col_s = $signed({4'b0000, display_col});
   assign row_s = $signed({5'b00000, display_row});
   assign dy    = row_s - Y_TOP_S;

   // Walk from the top digit down so the lowest matching k is the one kept.
   always_comb begin
      in_any    = 1'b0;
      digit_sel = '0;
      x_sel     = '0;
      y_sel     = '0;
      dx        = '0;
      row_ok    = (dy >= 0) && (dy < GH_S);
      for (int k = DIGITS - 1; k >= 0; k--) begin
         dx = col_s - box_left(k);
         if (row_ok && (dx >= 0) && (dx < GW_S) && !lz_blank[k]) begin
            in_any    = 1'b1;
            digit_sel = score_bcd[4*k +: 4];
            x_sel     = dx[5:0];
            y_sel     = dy[5:0];
         end
      end
   end

   // Stage 1: glyph ROM address and box hit
   logic [3:0] glyph_digit_p1;
   logic [5:0] glyph_x_p1, glyph_y_p1;
   logic       vld_p1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         glyph_digit_p1 <= '0;
         glyph_x_p1     <= '0;
         glyph_y_p1     <= '0;
         vld_p1         <= 1'b0;
      end else begin
         glyph_digit_p1 <= digit_sel;
         glyph_x_p1     <= x_sel;
         glyph_y_p1     <= y_sel;
         vld_p1         <= visible && in_any;
      end
   end

   assign glyph_digit = glyph_digit_p1;
   assign glyph_x     = glyph_x_p1;
   assign glyph_y     = glyph_y_p1;

   // Stage 2: colour from ROM pixel
   logic [11:0] rgb_p2;
   logic        vld_p2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rgb_p2 <= '0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         rgb_p2 <= (vld_p1 && glyph_pixel) ? (overflow ? OVF_RGB : FG_RGB) : 12'h000;
      end
   end

   assign num_visible = vld_p2;
   assign num_red     = rgb_p2[11:8];
   assign num_green   = rgb_p2[7:4];
   assign num_blue    = rgb_p2[3:0];

endmodule

// File: tb/tb_score_display_bcd.sv
// Bench for score_display_bcd: wrapping and saturating instances against an integer score model.
module tb_score_display_bcd;
   localparam int DIGITS = 4;
   localparam int TICK   = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] display_col;
   logic [10:0] display_row;
   logic        visible, hit, clear, bonus_valid;
   logic [3:0]  bonus_amt;
   logic        rom_all;

   logic [15:0] score0, score1;
   logic        ovf0, ovf1, gp0, gp1, nv0, nv1;
   logic [3:0]  gd0, gd1, r0, g0, b0, r1, g1, b1;
   logic [5:0]  gx0, gx1, gy0, gy1;
   logic [11:0] rgb0, rgb1;

   int chk_cnt = 0;
   int pass_cnt = 0;

   always #5 clock = ~clock;

   function automatic logic rom_bit(input logic [3:0] d, input logic [5:0] x, input logic [5:0] y,
                                    input logic all_on);
      return all_on | (x[2] ^ y[3] ^ d[0] ^ d[1]);
   endfunction

   assign gp0  = rom_bit(gd0, gx0, gy0, rom_all);
   assign gp1  = rom_bit(gd1, gx1, gy1, rom_all);
   assign rgb0 = {r0, g0, b0};
   assign rgb1 = {r1, g1, b1};

   score_display_bcd #(.DIGITS(DIGITS), .TICK_CYCLES(TICK), .SATURATE(0)) dut0 (
      .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
      .visible(visible), .hit(hit), .clear(clear), .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
      .score_bcd(score0), .overflow(ovf0), .glyph_digit(gd0), .glyph_x(gx0), .glyph_y(gy0),
      .glyph_pixel(gp0), .num_red(r0), .num_green(g0), .num_blue(b0), .num_visible(nv0));

   score_display_bcd #(.DIGITS(DIGITS), .TICK_CYCLES(TICK), .SATURATE(1)) dut1 (
      .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
      .visible(visible), .hit(hit), .clear(clear), .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
      .score_bcd(score1), .overflow(ovf1), .glyph_digit(gd1), .glyph_x(gx1), .glyph_y(gy1),
      .glyph_pixel(gp1), .num_red(r1), .num_green(g1), .num_blue(b1), .num_visible(nv1));

   // Reference model: integer score, shared tick phase, per-instance pixel pipeline.
   int          m_score[2];
   bit          m_ovf[2];
   int          m_cnt;
   bit          m_s1v[2];
   int          m_s1d[2], m_s1x[2], m_s1y[2];
   bit          m_vis[2];
   logic [11:0] m_rgb[2];

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic model_step();
      bit          tick, found, blank, nv;
      logic [11:0] nrgb;
      int          col, row, left, dig, x, y, amt, sum;
      col  = int'(display_col);
      row  = int'(display_row);
      tick = !hit && (m_cnt == TICK - 1);
      for (int d = 0; d < 2; d++) begin
         nv   = m_s1v[d];
         nrgb = (m_s1v[d] && rom_bit(4'(m_s1d[d]), 6'(m_s1x[d]), 6'(m_s1y[d]), rom_all))
                ? (m_ovf[d] ? 12'hF00 : 12'hFFF) : 12'h000;
         found = 0; dig = 0; x = 0; y = 0;
         for (int k = DIGITS - 1; k >= 0; k--) begin
            left = 1150 - 64 * k;
`ifdef SCORE_LZ_BLANK_EN
            blank = (k > 0) && (m_score[d] < pow10(k));
`else
            blank = 1'b0;
`endif
            if (col >= left && col < left + 48 && row >= 50 && row < 114 && !blank) begin
               found = 1;
               dig   = (m_score[d] / pow10(k)) % 10;
               x     = col - left;
               y     = row - 50;
            end
         end
         m_s1v[d] = visible && found;
         m_s1d[d] = dig; m_s1x[d] = x; m_s1y[d] = y;
         m_vis[d] = nv;  m_rgb[d] = nrgb;
         if (clear) begin
            m_score[d] = 0; m_ovf[d] = 0;
         end else begin
            amt = int'(tick) + ((bonus_valid && !hit && bonus_amt <= 4'd9) ? int'(bonus_amt) : 0);
            sum = m_score[d] + amt;
            if (sum >= 10000) begin
               m_ovf[d]   = 1;
               m_score[d] = (d == 1) ? 9999 : sum - 10000;
            end else m_score[d] = sum;
         end
      end
      if (clear) m_cnt = 0;
      else if (!hit) m_cnt = tick ? 0 : m_cnt + 1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      check("score0", score0, to_bcd(m_score[0]));
      check("score1", score1, to_bcd(m_score[1]));
      check("ovf0", ovf0, m_ovf[0]);
      check("ovf1", ovf1, m_ovf[1]);
      check("vis0", nv0, m_vis[0]);
      check("vis1", nv1, m_vis[1]);
      check("rgb0", rgb0, m_rgb[0]);
      check("rgb1", rgb1, m_rgb[1]);
      check("glyph0", {gd0, gx0, gy0}, {4'(m_s1d[0]), 6'(m_s1x[0]), 6'(m_s1y[0])});
   endtask

   // Clear, then reach target with the tick counter ending at phase ph; leaves hit=1.
   task automatic preload(input int target, input int ph);
      int n, b;
      n = ph;
      while (!((n / 4) <= target && (target - n / 4) <= 9 * n)) n += 4;
      clear = 1; hit = 1; bonus_valid = 0;
      cycle();
      clear = 0; hit = 0;
      b = target - n / 4;
      for (int i = 0; i < n; i++) begin
         bonus_valid = 1;
         bonus_amt   = 4'((b > 9) ? 9 : b);
         b -= int'(bonus_amt);
         cycle();
      end
      bonus_valid = 0; hit = 1;
   endtask

   typedef struct {
      int          pre;
      int          ph;
      logic        hit;
      logic        clr;
      logic        bv;
      logic [3:0]  ba;
      logic [15:0] exp0;
      logic        ov0;
      logic [15:0] exp1;
      logic        ov1;
   } vec_t;

   vec_t vt[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cols[3];
      logic exp_vis[3];

      vt[0] = '{99,   3, 1'b0, 1'b0, 1'b1, 4'd5,  16'h0105, 1'b0, 16'h0105, 1'b0};
      vt[1] = '{99,   0, 1'b0, 1'b0, 1'b1, 4'd12, 16'h0099, 1'b0, 16'h0099, 1'b0};
      vt[2] = '{99,   3, 1'b0, 1'b0, 1'b1, 4'd12, 16'h0100, 1'b0, 16'h0100, 1'b0};
      vt[3] = '{9998, 0, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0001, 1'b1, 16'h9999, 1'b1};
      vt[4] = '{9998, 3, 1'b0, 1'b0, 1'b1, 4'd9,  16'h0008, 1'b1, 16'h9999, 1'b1};
      vt[5] = '{9998, 0, 1'b1, 1'b0, 1'b1, 4'd3,  16'h9998, 1'b0, 16'h9998, 1'b0};
      vt[6] = '{1234, 3, 1'b1, 1'b1, 1'b1, 4'd9,  16'h0000, 1'b0, 16'h0000, 1'b0};
      vt[7] = '{0,    0, 1'b0, 1'b0, 1'b1, 4'd9,  16'h0009, 1'b0, 16'h0009, 1'b0};
      vt[8] = '{999,  3, 1'b0, 1'b0, 1'b0, 4'd0,  16'h1000, 1'b0, 16'h1000, 1'b0};
      vt[9] = '{9999, 3, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 16'h9999, 1'b1};

      reset = 1; display_col = 0; display_row = 0; visible = 0; hit = 0; clear = 0;
      bonus_valid = 0; bonus_amt = 0; rom_all = 1;
      for (int d = 0; d < 2; d++) begin
         m_score[d] = 0; m_ovf[d] = 0; m_s1v[d] = 0; m_s1d[d] = 0; m_s1x[d] = 0; m_s1y[d] = 0;
         m_vis[d] = 0; m_rgb[d] = 0;
      end
      m_cnt = 0;
      #23;
      check("reset_score0", score0, 16'h0000);
      check("reset_score1", score1, 16'h0000);
      check("reset_ovf", {ovf0, ovf1}, 2'b00);
      check("reset_vis", {nv0, nv1}, 2'b00);
      check("reset_rgb", {rgb0, rgb1}, 24'h0);
      check("reset_glyph", {gd0, gx0, gy0}, 16'h0);
      @(posedge clock); #1;
      reset = 0;

      for (int i = 0; i < 40; i++) cycle();
      check("run40_score", score0, 16'h0010);
      check("run40_ovf", ovf0, 1'b0);

      preload(50, 2);
      for (int i = 0; i < 20; i++) cycle();
      check("hit_frozen", score0, 16'h0050);
      hit = 0;
      cycle();
      check("hit_release1", score0, 16'h0050);
      cycle();
      check("hit_release2", score0, 16'h0051);

      for (int i = 0; i < 10; i++) begin
         preload(vt[i].pre, vt[i].ph);
         hit = vt[i].hit; clear = vt[i].clr; bonus_valid = vt[i].bv; bonus_amt = vt[i].ba;
         cycle();
         check($sformatf("vec%0d_score0", i), score0, vt[i].exp0);
         check($sformatf("vec%0d_ovf0", i), ovf0, vt[i].ov0);
         check($sformatf("vec%0d_score1", i), score1, vt[i].exp1);
         check($sformatf("vec%0d_ovf1", i), ovf1, vt[i].ov1);
         clear = 0; bonus_valid = 0; hit = 1;
      end

      display_col = 12'd1160; display_row = 11'd60; visible = 1; rom_all = 1;
      cycle(); cycle();
      check("ovf_colour0", rgb0, 12'hF00);
      check("ovf_colour1", rgb1, 12'hF00);
      hit = 0; bonus_valid = 1; bonus_amt = 4'd5;
      cycle();
      check("post_ovf_wrap", {score0, 3'b000, ovf0}, {16'h0005, 4'h1});
      check("post_ovf_sat", {score1, 3'b000, ovf1}, {16'h9999, 4'h1});
      bonus_valid = 0; clear = 1;
      cycle();
      check("clear_after_ovf", {score0, score1, 2'b00, ovf0, ovf1}, 36'h0);
      clear = 0;

      preload(7, 0);
      display_col = 0; display_row = 11'd60; visible = 1; rom_all = 1;
      cycle();
      for (int i = 0; i < 50; i++) begin
         display_col = 12'(1150 + i);
         cycle();
         if (i == 0) check("sweep_lat", nv0, 1'b0);
         else begin
            check($sformatf("sweep_vis_c%0d", 1149 + i), nv0, (1149 + i) <= 1197);
            check($sformatf("sweep_rgb_c%0d", 1149 + i), rgb0, ((1149 + i) <= 1197) ? 12'hFFF : 12'h000);
         end
         if (i < 48) check($sformatf("sweep_addr_c%0d", 1150 + i), {gd0, gx0}, {4'd7, 6'(i)});
      end

      display_col = 12'd1160; visible = 0;
      cycle(); cycle();
      check("invis_vis", nv0, 1'b0);
      check("invis_rgb", rgb0, 12'h000);
      visible = 1;
      cycle();
      check("vis_lat1", nv0, 1'b0);
      cycle();
      check("vis_lat2", nv0, 1'b1);

      preload(42, 0);
      cols[0] = 958; cols[1] = 1022; cols[2] = 1086;
`ifdef SCORE_LZ_BLANK_EN
      exp_vis[0] = 0; exp_vis[1] = 0; exp_vis[2] = 1;
`else
      exp_vis[0] = 1; exp_vis[1] = 1; exp_vis[2] = 1;
`endif
      display_row = 11'd60; visible = 1; rom_all = 1;
      for (int i = 0; i < 3; i++) begin
         display_col = 12'(cols[i]);
         cycle(); cycle();
         check($sformatf("blank_c%0d", cols[i]), {nv0, nv1}, {exp_vis[i], exp_vis[i]});
      end

      preload(9500, 1);
      for (int i = 0; i < 3000; i++) begin
         hit         = ($urandom_range(0, 3) == 0);
         clear       = ($urandom_range(0, 699) == 0);
         bonus_valid = ($urandom_range(0, 2) == 0);
         bonus_amt   = 4'($urandom_range(0, 15));
         display_col = 12'($urandom_range(880, 1230));
         display_row = 11'($urandom_range(40, 125));
         visible     = ($urandom_range(0, 9) != 0);
         rom_all     = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
